// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: program ROM address/data plus the valid/ready stream toward decode.
// The master modport is the fetch unit; the slave modport is the ROM/decode environment.
interface instr_fetch_unit_if #(
   parameter int PC_W = 32
);
   logic [PC_W-1:0] imem_addr;
   logic [31:0]     imem_data;
   logic            if_valid;
   logic            if_ready;
   logic [31:0]     if_instr;
   logic [PC_W-1:0] if_pc;

   modport master (
      output imem_addr,
      input  imem_data,
      output if_valid,
      input  if_ready,
      output if_instr,
      output if_pc
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      input  if_valid,
      output if_ready,
      input  if_instr,
      input  if_pc
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks the program ROM from a start PC, buffers {pc,instr} toward decode,
// stops on HALT (all-zero word) or out-of-range PC. Optional counters under `IFU_PERF_EN.
module instr_fetch_unit #(
   parameter int PC_W       = 32,
   parameter int IMEM_DEPTH = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [PC_W-1:0]     start_pc,
   input  logic                redirect_valid,
   input  logic [PC_W-1:0]     redirect_pc,
   instr_fetch_unit_if.master  bus,
   output logic                halted,
   output logic                fault
`ifdef IFU_PERF_EN
   ,
   output logic [31:0]         fetch_count,
   output logic [31:0]         stall_count
`endif
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_p0, pc_d;
   logic [PC_W-1:0] fifo_pc    [FIFO_DEPTH];
   logic [31:0]     fifo_instr [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            head_vld, full, pop, push, flush;
   logic            do_start, do_redirect, oor, halt_set, fault_set;

   assign head_vld = (count != '0);
   assign full     = (count == (AW+1)'(FIFO_DEPTH));
   assign pop      = head_vld && bus.if_ready;
   assign oor      = (pc_p0 >= PC_W'(IMEM_DEPTH));

   assign bus.imem_addr = pc_p0;
   assign bus.if_valid  = head_vld;
   assign bus.if_instr  = head_vld ? fifo_instr[rd_ptr] : '0;
   assign bus.if_pc     = head_vld ? fifo_pc[rd_ptr]    : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Redirect outranks everything: it flushes the buffer and discards this cycle's fetch and pop.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_p0;
      push        = 1'b0;
      flush       = 1'b0;
      do_start    = 1'b0;
      halt_set    = 1'b0;
      fault_set   = 1'b0;
      do_redirect = redirect_valid && (state_q != IDLE);
      if (do_redirect) begin
         state_d = RUN;
         pc_d    = redirect_pc;
         flush   = 1'b1;
      end else begin
         case (state_q)
            IDLE, HALTED: begin
               if (start) begin
                  state_d  = RUN;
                  pc_d     = start_pc;
                  flush    = 1'b1;
                  do_start = 1'b1;
               end
            end
            RUN: begin
               if (oor) begin
                  fault_set = 1'b1;
                  state_d   = HALTED;
               end else if (!full || pop) begin
                  push = 1'b1;
                  if (bus.imem_data == 32'h0) begin
                     halt_set = 1'b1;
                     state_d  = HALTED;
                  end else begin
                     pc_d = pc_p0 + PC_W'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Fetch stage: pc and buffer bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_p0  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         halted <= 1'b0;
         fault  <= 1'b0;
      end else begin
         pc_p0 <= pc_d;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
         end
         if (flush)                     halted <= 1'b0;
         else if (halt_set || fault_set) halted <= 1'b1;
         if (do_start)       fault <= 1'b0;
         else if (fault_set) fault <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]    <= pc_p0;
         fifo_instr[wr_ptr] <= bus.imem_data;
      end
   end

`ifdef IFU_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else if (do_start) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         if (push) fetch_count <= sat_inc(fetch_count);
         if ((state_q == RUN) && full && !pop) stall_count <= sat_inc(stall_count);
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized ready/redirect
// traffic checked against a program-walk reference model.
module tb_instr_fetch_unit;
   localparam int PC_W       = 32;
   localparam int IMEM_DEPTH = 32;
   localparam int FIFO_DEPTH = 2;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     instr;
   } entry_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [PC_W-1:0] start_pc = '0;
   logic            redirect_valid = 1'b0;
   logic [PC_W-1:0] redirect_pc = '0;
   logic            halted, fault;
`ifdef IFU_PERF_EN
   logic [31:0]     fetch_count, stall_count;
`endif

   logic [31:0] rom [64];
   int          n_cmp = 0;
   int          n_bad = 0;
   entry_t      exp_q[$];
   logic        exp_fault;

   instr_fetch_unit_if #(.PC_W(PC_W)) bus ();

   always #5 clk = ~clk;

   assign bus.imem_data = (bus.imem_addr < 64) ? rom[bus.imem_addr[5:0]] : 32'hDEAD_BEEF;

   instr_fetch_unit #(.PC_W(PC_W), .IMEM_DEPTH(IMEM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .start_pc       (start_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus),
      .halted         (halted),
      .fault          (fault)
`ifdef IFU_PERF_EN
      ,
      .fetch_count    (fetch_count),
      .stall_count    (stall_count)
`endif
   );

   // Reference: the sequence decode must receive when fetching begins at 'from'.
   function automatic void build_walk(input logic [PC_W-1:0] from);
      logic [PC_W-1:0] p;
      p = from;
      exp_q.delete();
      exp_fault = 1'b0;
      for (int i = 0; i <= IMEM_DEPTH; i++) begin
         if (p >= PC_W'(IMEM_DEPTH)) begin
            exp_fault = 1'b1;
            break;
         end
         exp_q.push_back({p, rom[p[5:0]]});
         if (rom[p[5:0]] == 32'h0) break;
         p = p + PC_W'(1);
      end
   endfunction

   task automatic load_prog0();
      for (int i = 0; i < 7; i++) rom[i] = $urandom | 32'h1;
      rom[7] = 32'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if (bus.if_valid !== 1'b0 || bus.if_pc !== '0 || bus.if_instr !== '0 || bus.imem_addr !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs valid=%0b pc=%0h instr=%0h addr=%0h required 0/0/0/0",
                  bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_addr);
      end
      n_cmp++;
      if (halted !== 1'b0 || fault !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_flags halted=%0b fault=%0b required 0/0", halted, fault);
      end
`ifdef IFU_PERF_EN
      n_cmp++;
      if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
         n_bad++;
         $display("FAIL reset_perf fetch=%0d stall=%0d required 0/0", fetch_count, stall_count);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_sequential();
      load_prog0();
      @(negedge clk);
      bus.if_ready = 1'b1;
      start_pc = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (bus.if_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL seq_latency valid=%0b required 0", bus.if_valid);
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.if_valid !== 1'b1 || bus.if_pc !== PC_W'(k) || bus.if_instr !== rom[k]) begin
            n_bad++;
            $display("FAIL seq_word%0d valid=%0b pc=%0h instr=%0h required 1/%0h/%0h",
                     k, bus.if_valid, bus.if_pc, bus.if_instr, k, rom[k]);
         end
         n_cmp++;
         if (halted !== (k == 7)) begin
            n_bad++;
            $display("FAIL seq_halted%0d halted=%0b required %0b", k, halted, (k == 7));
         end
      end
      @(negedge clk);
      n_cmp++;
      if (bus.if_valid !== 1'b0 || halted !== 1'b1 || bus.imem_addr !== PC_W'(7) || fault !== 1'b0) begin
         n_bad++;
         $display("FAIL seq_end valid=%0b halted=%0b addr=%0h fault=%0b required 0/1/7/0",
                  bus.if_valid, halted, bus.imem_addr, fault);
      end
`ifdef IFU_PERF_EN
      n_cmp++;
      if (fetch_count !== 32'd8) begin
         n_bad++;
         $display("FAIL seq_fetch_count got=%0d required 8", fetch_count);
      end
`endif
   endtask

   task automatic test_stall();
      @(negedge clk);
      bus.if_ready = 1'b0;
      start_pc = '0;
      start = 1'b1;
      build_walk('0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      n_cmp++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== '0 || bus.imem_addr !== PC_W'(2)) begin
         n_bad++;
         $display("FAIL stall_hold valid=%0b pc=%0h addr=%0h required 1/0/2",
                  bus.if_valid, bus.if_pc, bus.imem_addr);
      end
      for (int c = 0; c < 100 && !(exp_q.size() == 0 && halted && !bus.if_valid); c++) begin
         bus.if_ready = 1'b1;
         if (bus.if_valid && bus.if_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL stall_extra pc=%0h required no word", bus.if_pc);
            end else if ({bus.if_pc, bus.if_instr} !== exp_q[0]) begin
               n_bad++;
               $display("FAIL stall_order got=%0h/%0h required %0h/%0h",
                        bus.if_pc, bus.if_instr, exp_q[0].pc, exp_q[0].instr);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         @(negedge clk);
      end
      n_cmp++;
      if (exp_q.size() != 0 || halted !== 1'b1) begin
         n_bad++;
         $display("FAIL stall_drain left=%0d halted=%0b required 0/1", exp_q.size(), halted);
      end
`ifdef IFU_PERF_EN
      n_cmp++;
      if (stall_count !== 32'd3 || fetch_count !== 32'd8) begin
         n_bad++;
         $display("FAIL stall_perf stall=%0d fetch=%0d required 3/8", stall_count, fetch_count);
      end
`endif
   endtask

   task automatic test_restart_ignored();
      for (int i = 8; i < 19; i++) rom[i] = $urandom | 32'h1;
      rom[19] = 32'h0;
      @(negedge clk);
      bus.if_ready = 1'b1;
      start_pc = PC_W'(8);
      start = 1'b1;
      build_walk(PC_W'(8));
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 100 && !(exp_q.size() == 0 && halted && !bus.if_valid); c++) begin
         start    = (c == 2);
         start_pc = (c == 2) ? '0 : PC_W'(8);
         if (bus.if_valid && bus.if_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL restart_extra pc=%0h required no word", bus.if_pc);
            end else if ({bus.if_pc, bus.if_instr} !== exp_q[0]) begin
               n_bad++;
               $display("FAIL restart_order got=%0h/%0h required %0h/%0h",
                        bus.if_pc, bus.if_instr, exp_q[0].pc, exp_q[0].instr);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         @(negedge clk);
      end
      start = 1'b0;
      n_cmp++;
      if (exp_q.size() != 0 || halted !== 1'b1 || bus.imem_addr !== PC_W'(19)) begin
         n_bad++;
         $display("FAIL restart_end left=%0d halted=%0b addr=%0h required 0/1/13",
                  exp_q.size(), halted, bus.imem_addr);
      end
   endtask

   task automatic test_redirect();
      @(negedge clk);
      bus.if_ready = 1'b0;
      start_pc = PC_W'(9);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== PC_W'(9) || bus.imem_addr !== PC_W'(11)) begin
         n_bad++;
         $display("FAIL redir_pre valid=%0b pc=%0h addr=%0h required 1/9/b",
                  bus.if_valid, bus.if_pc, bus.imem_addr);
      end
      redirect_valid = 1'b1;
      redirect_pc = PC_W'(14);
      bus.if_ready = 1'b1;
      build_walk(PC_W'(14));
      @(negedge clk);
      redirect_valid = 1'b0;
      n_cmp++;
      if (bus.if_valid !== 1'b0 || bus.imem_addr !== PC_W'(14)) begin
         n_bad++;
         $display("FAIL redir_flush valid=%0b addr=%0h required 0/e", bus.if_valid, bus.imem_addr);
      end
      for (int pass = 0; pass < 2; pass++) begin
         for (int c = 0; c < 100 && !(exp_q.size() == 0 && halted && !bus.if_valid); c++) begin
            if (bus.if_valid && bus.if_ready) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL redir_extra%0d pc=%0h required no word", pass, bus.if_pc);
               end else if ({bus.if_pc, bus.if_instr} !== exp_q[0]) begin
                  n_bad++;
                  $display("FAIL redir_order%0d got=%0h/%0h required %0h/%0h",
                           pass, bus.if_pc, bus.if_instr, exp_q[0].pc, exp_q[0].instr);
               end
               if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            @(negedge clk);
         end
         n_cmp++;
         if (exp_q.size() != 0 || halted !== 1'b1) begin
            n_bad++;
            $display("FAIL redir_drain%0d left=%0d halted=%0b required 0/1", pass, exp_q.size(), halted);
         end
         if (pass == 0) begin
            redirect_valid = 1'b1;
            redirect_pc = PC_W'(16);
            build_walk(PC_W'(16));
            @(negedge clk);
            redirect_valid = 1'b0;
            n_cmp++;
            if (halted !== 1'b0 || bus.imem_addr !== PC_W'(16)) begin
               n_bad++;
               $display("FAIL redir_resume halted=%0b addr=%0h required 0/10", halted, bus.imem_addr);
            end
         end
      end
   endtask

   task automatic test_fault();
      for (int i = 0; i < 32; i++) rom[i] = $urandom | 32'h1;
      @(negedge clk);
      bus.if_ready = 1'b1;
      start_pc = PC_W'(30);
      start = 1'b1;
      build_walk(PC_W'(30));
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 100 && !(exp_q.size() == 0 && halted && !bus.if_valid); c++) begin
         if (bus.if_valid && bus.if_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL fault_extra pc=%0h required no word", bus.if_pc);
            end else if ({bus.if_pc, bus.if_instr} !== exp_q[0]) begin
               n_bad++;
               $display("FAIL fault_order got=%0h/%0h required %0h/%0h",
                        bus.if_pc, bus.if_instr, exp_q[0].pc, exp_q[0].instr);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0 || fault !== exp_fault || halted !== 1'b1) begin
         n_bad++;
         $display("FAIL fault_flags left=%0d fault=%0b halted=%0b required 0/%0b/1",
                  exp_q.size(), fault, halted, exp_fault);
      end
      n_cmp++;
      if (bus.if_valid !== 1'b0 || bus.imem_addr !== PC_W'(32)) begin
         n_bad++;
         $display("FAIL fault_stop valid=%0b addr=%0h required 0/20", bus.if_valid, bus.imem_addr);
      end
   endtask

   task automatic test_random();
      int nredir;
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < 32; i++) rom[i] = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom | 32'h1);
         @(negedge clk);
         start_pc = PC_W'($urandom_range(0, 31));
         start = 1'b1;
         build_walk(start_pc);
         @(negedge clk);
         start = 1'b0;
         nredir = 0;
         for (int c = 0; c < 800 && !(exp_q.size() == 0 && halted && !bus.if_valid); c++) begin
            bus.if_ready = 1'($urandom_range(0, 1));
            redirect_valid = 1'b0;
            if (nredir < 2 && $urandom_range(0, 19) == 0) begin
               redirect_valid = 1'b1;
               redirect_pc = PC_W'($urandom_range(0, 31));
               nredir++;
            end
            if (bus.if_valid && bus.if_ready && !redirect_valid) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL rand%0d_extra pc=%0h required no word", it, bus.if_pc);
               end else if ({bus.if_pc, bus.if_instr} !== exp_q[0]) begin
                  n_bad++;
                  $display("FAIL rand%0d_order got=%0h/%0h required %0h/%0h",
                           it, bus.if_pc, bus.if_instr, exp_q[0].pc, exp_q[0].instr);
               end
               if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (redirect_valid) build_walk(redirect_pc);
            @(negedge clk);
         end
         redirect_valid = 1'b0;
         n_cmp++;
         if (exp_q.size() != 0 || halted !== 1'b1) begin
            n_bad++;
            $display("FAIL rand%0d_done left=%0d halted=%0b required 0/1", it, exp_q.size(), halted);
         end
         if (exp_fault) begin
            n_cmp++;
            if (fault !== 1'b1) begin
               n_bad++;
               $display("FAIL rand%0d_fault fault=%0b required 1", it, fault);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      load_prog0();
      @(negedge clk);
      bus.if_ready = 1'b0;
      start_pc = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (bus.if_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL arst_pre valid=%0b required 1", bus.if_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.if_valid !== 1'b0 || bus.if_pc !== '0 || bus.if_instr !== '0 || bus.imem_addr !== '0 ||
          halted !== 1'b0 || fault !== 1'b0) begin
         n_bad++;
         $display("FAIL arst_now valid=%0b pc=%0h instr=%0h addr=%0h halted=%0b fault=%0b required all 0",
                  bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_addr, halted, fault);
      end
`ifdef IFU_PERF_EN
      n_cmp++;
      if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
         n_bad++;
         $display("FAIL arst_perf fetch=%0d stall=%0d required 0/0", fetch_count, stall_count);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      bus.if_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (bus.if_valid !== 1'b0 || bus.imem_addr !== '0 || halted !== 1'b0) begin
         n_bad++;
         $display("FAIL arst_idle valid=%0b addr=%0h halted=%0b required 0/0/0",
                  bus.if_valid, bus.imem_addr, halted);
      end
   endtask

   initial begin
      bus.if_ready = 1'b0;
      for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 | 32'(i);
      test_reset();
      test_sequential();
      test_stall();
      test_restart_ignored();
      test_redirect();
      test_fault();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
